// File: rtl/rotary_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : rotary_pkg                                                 |
// | Shared types for the rotary-encoder parameter bank controller:       |
// | write-port arbiter state encoding and the pending-step record.       |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package rotary_pkg;

  // Widest bank the controller supports; the pending record is sized for
  // it so the type does not depend on the top-level NUM_CH parameter.
  localparam int NUM_CH_MAX = 16;
  localparam int CH_W_MAX   = $clog2(NUM_CH_MAX);

  // The state names what the bank write port did in the previous cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_ENC  = 2'd2
  } arb_state_t;

  // One encoder step parked while the CPU owns the write port.
  typedef struct packed {
    logic [CH_W_MAX-1:0] ch;
    logic                dir;   // 1 = +1, 0 = -1
  } pend_t;

endpackage
`default_nettype wire

// File: rtl/rotary_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rotary_debounce                                            |
// | Two-flop synchroniser followed by a stable-level counter. The output |
// | level flips only after DEB_CYC consecutive synced samples differ     |
// | from it; any sample matching the current level restarts the count.  |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module rotary_debounce #(
  parameter int DEB_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level
);

  localparam int              CNT_W    = $clog2(DEB_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronise the raw pin and accept a new level once it has been stable long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rotary_param_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rotary_param_ctrl                                          |
// | Rotary-encoder parameter bank: debounced A/B/SW, quadrature step     |
// | decode, channel select on button press, and a single bank write      |
// | port shared between CPU writes (priority) and encoder steps.         |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module rotary_param_ctrl
  import rotary_pkg::*;
#(
  parameter int NUM_CH  = 10,
  parameter int DW      = 32,
  parameter int DEB_CYC = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_pin,
  input  logic                      b_pin,
  input  logic                      sw_pin,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [$clog2(NUM_CH)-1:0] wr_sel,
  input  logic [DW-1:0]             wr_data,
  input  logic [$clog2(NUM_CH)-1:0] rd_sel,
  output logic [DW-1:0]             rd_data,
  output logic [$clog2(NUM_CH)-1:0] cur_sel,
  output logic                      step_lost
);

  localparam int              CH_W    = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic a_deb, b_deb, sw_deb;
  logic a_prev, sw_prev;
  logic step_evt, btn_evt;
  pend_t new_step;

  rotary_debounce #(.DEB_CYC(DEB_CYC)) u_deb_a  (.clk(clk), .rst(rst), .pin(a_pin),  .level(a_deb));
  rotary_debounce #(.DEB_CYC(DEB_CYC)) u_deb_b  (.clk(clk), .rst(rst), .pin(b_pin),  .level(b_deb));
  rotary_debounce #(.DEB_CYC(DEB_CYC)) u_deb_sw (.clk(clk), .rst(rst), .pin(sw_pin), .level(sw_deb));

  // Previous debounced levels for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_prev  <= 1'b1;
      sw_prev <= 1'b1;
    end else begin
      a_prev  <= a_deb;
      sw_prev <= sw_deb;
    end
  end

  // A falling edge of A is one detent; B at that moment gives the direction.
  assign step_evt     = a_prev & ~a_deb;
  assign btn_evt      = sw_prev & ~sw_deb;
  assign new_step.ch  = CH_W_MAX'(cur_sel);
  assign new_step.dir = b_deb;

  // Button press advances the edited channel; a same-cycle step already captured the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_sel <= '0;
    end else if (btn_evt) begin
      cur_sel <= (cur_sel == LAST_CH) ? '0 : cur_sel + CH_W'(1);
    end
  end

  arb_state_t          state, state_nx;
  logic                cpu_prev2;   // an accepted CPU write two cycles back
  logic                cpu_fire;
  logic                drain;
  logic                pend_valid;
  pend_t               pend;
  logic                bank_we;
  logic                bank_from_cpu;
  logic                bank_dir;
  logic [CH_W_MAX-1:0] bank_ch;

  // Arbiter state register plus a one-cycle-older CPU-write marker for the back-pressure rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cpu_prev2 <= 1'b0;
    end else begin
      state     <= state_nx;
      cpu_prev2 <= (state == ST_CPU);
    end
  end

  // Grant the write port: CPU first, then a parked step, then a fresh step.
  // Every state applies the same priority; the state only records last cycle's owner.
  always_comb begin
    wr_ready      = ~(pend_valid & (state == ST_CPU) & cpu_prev2);
    cpu_fire      = wr_valid & wr_ready;
    drain         = 1'b0;
    state_nx      = ST_IDLE;
    bank_we       = 1'b0;
    bank_from_cpu = 1'b1;
    bank_dir      = 1'b0;
    bank_ch       = CH_W_MAX'(wr_sel);
    if (cpu_fire) begin
      state_nx = ST_CPU;
      bank_we  = 1'b1;
    end else if (pend_valid) begin
      state_nx      = ST_ENC;
      drain         = 1'b1;
      bank_we       = 1'b1;
      bank_from_cpu = 1'b0;
      bank_ch       = pend.ch;
      bank_dir      = pend.dir;
    end else if (step_evt) begin
      state_nx      = ST_ENC;
      bank_we       = 1'b1;
      bank_from_cpu = 1'b0;
      bank_ch       = new_step.ch;
      bank_dir      = new_step.dir;
    end
  end

  // One-deep pending slot: park a step that lost to the CPU, drop it if the slot is busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend       <= '0;
      step_lost  <= 1'b0;
    end else if (cpu_fire) begin
      if (step_evt) begin
        if (!pend_valid) begin
          pend_valid <= 1'b1;
          pend       <= new_step;
        end else begin
          step_lost <= 1'b1;
        end
      end
    end else if (drain) begin
      pend_valid <= step_evt;
      if (step_evt) begin
        pend <= new_step;
      end
    end
  end

  logic [DW-1:0] bank [NUM_CH];

  // Bank write port and registered read mux; unmatched channel numbers write nothing and read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        bank[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bank_we && bank_ch == CH_W_MAX'(i)) begin
          if (bank_from_cpu) begin
            bank[i] <= wr_data;
          end else if (bank_dir) begin
            bank[i] <= bank[i] + DW'(1);
          end else begin
            bank[i] <= bank[i] - DW'(1);
          end
        end
      end
      rd_data <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_sel == CH_W'(i)) begin
          rd_data <= bank[i];
        end
      end
    end
  end

endmodule
`default_nettype wire
